pipe_stall_ctrl: RTL and testbench

//  Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_ctrl_pkg.sv | 30 +++
 rtl/pipe_hazard_detect.sv | 17 +
 rtl/pipe_stall_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: state encoding,
// the strobe bundle driven to the pipeline registers, and pipeline constants.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      MWAIT = 2'd2,
      HALT  = 2'd3
   } state_t;

   // All-zero instruction the datapath loads into a flushed register
   localparam logic [31:0] NOP_INSTR = 32'h0;

   // Register 0 is hardwired, so a load targeting it never creates a hazard
   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic pc_en;
      logic pc_redirect;
      logic ifid_en;
      logic idex_en;
      logic exmem_en;
      logic memwb_en;
      logic ifid_flush;
      logic idex_flush;
      logic exmem_flush;
   } ctrl_t;

endpackage

// File: rtl/pipe_hazard_detect.sv
// Load-use hazard compare: the instruction in IF/ID reads the register that
// the load currently in ID/EX is about to write.
module pipe_hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       idex_memread,
   input  logic [4:0] idex_rt,
   output logic       hazard
);

   // Pure compare; a load into the zero register is harmless
   assign hazard = idex_memread && (idex_rt != REG_ZERO) &&
                   ((idex_rt == id_rs) || (idex_rt == id_rt));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central pipeline sequencer: register enables, flush strobes, PC control,
// data-memory wait handling and halt.
// Optional feature: define PIPE_STALL_CTRL_PERF_EN to add stall/flush
// performance counters as extra outputs.
module pipe_stall_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 8
)(
   input  logic       clock,
   input  logic       reset_n,
   input  logic       start,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       idex_memread,
   input  logic [4:0] idex_rt,
   input  logic       exmem_branch,
   input  logic       exmem_zero,
   input  logic       exmem_jump,
   input  logic       dmem_req,
   input  logic       dmem_ready,
   input  logic       wb_halt,
   output logic       pc_en,
   output logic       pc_redirect,
   output logic       ifid_en,
   output logic       idex_en,
   output logic       exmem_en,
   output logic       memwb_en,
   output logic       ifid_flush,
   output logic       idex_flush,
   output logic       exmem_flush,
   output logic       running,
   output logic       mem_err
`ifdef PIPE_STALL_CTRL_PERF_EN
   ,
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_flush_cnt
`endif
);

   state_t           state;
   state_t           next_state;
   logic [CNT_W-1:0] wait_cnt;
   logic             hazard;
   logic             taken;
   logic             mem_stall;
   logic             timeout;
   ctrl_t            run_ctrl;
   ctrl_t            ctrl;

   pipe_hazard_detect u_hazard (
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .idex_memread (idex_memread),
      .idex_rt      (idex_rt),
      .hazard       (hazard)
   );

   assign taken     = (exmem_branch && exmem_zero) || exmem_jump;
   assign mem_stall = dmem_req && !dmem_ready;
   assign timeout   = (state == MWAIT) && !dmem_ready &&
                      (wait_cnt == CNT_W'(MEM_TIMEOUT));

   // Strobes for a cycle in which memory is not blocking: redirect beats load-use
   always_comb begin
      run_ctrl = '0;
      if (taken) begin
         run_ctrl = '{pc_en: 1'b1, pc_redirect: 1'b1, ifid_en: 1'b1,
                      idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
                      ifid_flush: 1'b1, idex_flush: 1'b1, exmem_flush: 1'b1};
      end else if (hazard) begin
         run_ctrl = '{pc_en: 1'b0, pc_redirect: 1'b0, ifid_en: 1'b0,
                      idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
                      ifid_flush: 1'b0, idex_flush: 1'b1, exmem_flush: 1'b0};
      end else begin
         run_ctrl = '{pc_en: 1'b1, pc_redirect: 1'b0, ifid_en: 1'b1,
                      idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
                      ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0};
      end
   end

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= next_state;
   end

   // Next-state logic; a halt in write-back overrides every other transition
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:  if (start) next_state = RUN;
         RUN: begin
            if (wb_halt)        next_state = HALT;
            else if (mem_stall) next_state = MWAIT;
         end
         MWAIT: begin
            if (wb_halt)         next_state = HALT;
            else if (dmem_ready) next_state = RUN;
            else if (timeout)    next_state = HALT;
         end
         HALT:  next_state = HALT;
         default: next_state = IDLE;
      endcase
   end

   // Output strobes; everything is frozen in IDLE, HALT and while memory waits
   always_comb begin
      ctrl = '0;
      unique case (state)
         RUN:     if (!mem_stall) ctrl = run_ctrl;
         MWAIT:   if (dmem_ready) ctrl = run_ctrl;
         default: ctrl = '0;
      endcase
   end

   assign pc_en       = ctrl.pc_en;
   assign pc_redirect = ctrl.pc_redirect;
   assign ifid_en     = ctrl.ifid_en;
   assign idex_en     = ctrl.idex_en;
   assign exmem_en    = ctrl.exmem_en;
   assign memwb_en    = ctrl.memwb_en;
   assign ifid_flush  = ctrl.ifid_flush;
   assign idex_flush  = ctrl.idex_flush;
   assign exmem_flush = ctrl.exmem_flush;
   assign running     = (state == RUN) || (state == MWAIT);

   // Wait counter: starts at 1 on entering MWAIT, counts while waiting, else clear
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         wait_cnt <= '0;
      else if (state == RUN && next_state == MWAIT)
         wait_cnt <= CNT_W'(1);
      else if (state == MWAIT && next_state == MWAIT)
         wait_cnt <= wait_cnt + CNT_W'(1);
      else
         wait_cnt <= '0;
   end

   // Sticky memory timeout flag, cleared only by reset
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)     mem_err <= 1'b0;
      else if (timeout) mem_err <= 1'b1;
   end

`ifdef PIPE_STALL_CTRL_PERF_EN
   logic stall_event;
   logic flush_event;

   assign stall_event = (state == MWAIT) ||
                        ((state == RUN) && ctrl.idex_flush && !ctrl.exmem_flush);
   assign flush_event = ctrl.pc_redirect;

   // Saturating performance counters, active only while the pipeline is live
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         perf_stall_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (stall_event && perf_stall_cnt != 32'hFFFF_FFFF)
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         if (flush_event && perf_flush_cnt != 32'hFFFF_FFFF)
            perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed self-checking bench for pipe_stall_ctrl, built with MEM_TIMEOUT=4.
module tb_pipe_stall_ctrl;

   // Output vector order: pc_en, pc_redirect, ifid_en, idex_en, exmem_en,
   // memwb_en, ifid_flush, idex_flush, exmem_flush, running, mem_err
   localparam logic [10:0] ALL_OFF  = 11'b00000000000;
   localparam logic [10:0] RUN_NORM = 11'b10111100010;
   localparam logic [10:0] STALL    = 11'b00011101010;
   localparam logic [10:0] REDIRECT = 11'b11111111110;
   localparam logic [10:0] WAITING  = 11'b00000000010;
   localparam logic [10:0] HALT_ERR = 11'b00000000001;

   logic clock = 1'b0;
   logic resetN = 1'b0;
   logic start = 1'b0;
   logic [4:0] idRs = '0;
   logic [4:0] idRt = '0;
   logic idexMemread = 1'b0;
   logic [4:0] idexRt = '0;
   logic exmemBranch = 1'b0;
   logic exmemZero = 1'b0;
   logic exmemJump = 1'b0;
   logic dmemReq = 1'b0;
   logic dmemReady = 1'b0;
   logic wbHalt = 1'b0;

   logic pcEn, pcRedirect, ifidEn, idexEn, exmemEn, memwbEn;
   logic ifidFlush, idexFlush, exmemFlush, running, memErr;
   logic [10:0] obsOut;

   int checkCount = 0;
   int errorCount = 0;

`ifdef PIPE_STALL_CTRL_PERF_EN
   logic [31:0] perfStallCnt;
   logic [31:0] perfFlushCnt;
`endif

   pipe_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
      .clock        (clock),
      .reset_n      (resetN),
      .start        (start),
      .id_rs        (idRs),
      .id_rt        (idRt),
      .idex_memread (idexMemread),
      .idex_rt      (idexRt),
      .exmem_branch (exmemBranch),
      .exmem_zero   (exmemZero),
      .exmem_jump   (exmemJump),
      .dmem_req     (dmemReq),
      .dmem_ready   (dmemReady),
      .wb_halt      (wbHalt),
      .pc_en        (pcEn),
      .pc_redirect  (pcRedirect),
      .ifid_en      (ifidEn),
      .idex_en      (idexEn),
      .exmem_en     (exmemEn),
      .memwb_en     (memwbEn),
      .ifid_flush   (ifidFlush),
      .idex_flush   (idexFlush),
      .exmem_flush  (exmemFlush),
      .running      (running),
      .mem_err      (memErr)
`ifdef PIPE_STALL_CTRL_PERF_EN
      ,
      .perf_stall_cnt (perfStallCnt),
      .perf_flush_cnt (perfFlushCnt)
`endif
   );

   assign obsOut = {pcEn, pcRedirect, ifidEn, idexEn, exmemEn, memwbEn,
                    ifidFlush, idexFlush, exmemFlush, running, memErr};

   // 10 ns clock
   always #5 clock = ~clock;

   // Count one comparison and report it if the observed value differs
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed %b expected %b", tag, observed[10:0], expected[10:0]);
      end
   endtask

   // Drive one cycle of inputs just after the falling edge, let outputs settle
   task automatic applyStimulus(input logic st, input logic memread,
                                input logic [4:0] ldRt, input logic [4:0] rs,
                                input logic [4:0] rt, input logic br,
                                input logic zr, input logic jmp,
                                input logic req, input logic rdy,
                                input logic hlt);
      @(negedge clock);
      start = st; idexMemread = memread; idexRt = ldRt; idRs = rs; idRt = rt;
      exmemBranch = br; exmemZero = zr; exmemJump = jmp;
      dmemReq = req; dmemReady = rdy; wbHalt = hlt;
      #1;
   endtask

   task automatic quietStep();
      applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
   endtask

   // Asynchronous reset pulse taken mid-cycle, then released on a falling edge
   task automatic pulseReset(input string tag);
      #1 resetN = 1'b0;
      #1 checkOutput(tag, 32'(obsOut), 32'(ALL_OFF));
      @(negedge clock);
      resetN = 1'b1;
   endtask

   initial begin
      // T1: reset, idle without start, then start
      #2 checkOutput("reset_state", 32'(obsOut), 32'(ALL_OFF));
      @(negedge clock);
      resetN = 1'b1;
      for (int i = 0; i < 10; i++) begin
         quietStep();
         checkOutput("idle_no_start", 32'(obsOut), 32'(ALL_OFF));
      end
      applyStimulus(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
      checkOutput("start_cycle_idle", 32'(obsOut), 32'(ALL_OFF));
      quietStep();
      checkOutput("run_after_start", 32'(obsOut), 32'(RUN_NORM));
      applyStimulus(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
      checkOutput("start_ignored_in_run", 32'(obsOut), 32'(RUN_NORM));

      // T2: load-use stalls
      applyStimulus(0, 1, 5'd8, 5'd8, 5'd3, 0, 0, 0, 0, 0, 0);
      checkOutput("loaduse_rs", 32'(obsOut), 32'(STALL));
      quietStep();
      checkOutput("after_loaduse", 32'(obsOut), 32'(RUN_NORM));
      applyStimulus(0, 1, 5'd9, 5'd2, 5'd9, 0, 0, 0, 0, 0, 0);
      checkOutput("loaduse_rt", 32'(obsOut), 32'(STALL));
      applyStimulus(0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
      checkOutput("loaduse_reg_zero", 32'(obsOut), 32'(RUN_NORM));
      applyStimulus(0, 1, 5'd7, 5'd6, 5'd5, 0, 0, 0, 0, 0, 0);
      checkOutput("load_no_match", 32'(obsOut), 32'(RUN_NORM));

      // T3: branches and jumps
      applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 0, 0);
      checkOutput("branch_taken", 32'(obsOut), 32'(REDIRECT));
      applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0, 0);
      checkOutput("branch_not_taken", 32'(obsOut), 32'(RUN_NORM));
      applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0);
      checkOutput("jump", 32'(obsOut), 32'(REDIRECT));
      applyStimulus(0, 1, 5'd8, 5'd8, 5'd0, 1, 1, 0, 0, 0, 0);
      checkOutput("branch_beats_loaduse", 32'(obsOut), 32'(REDIRECT));

      // T4: three cycles of memory wait, then resume
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0);
         checkOutput("mem_wait", 32'(obsOut), 32'(WAITING));
      end
      applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, 0);
      checkOutput("mem_ready_resume", 32'(obsOut), 32'(RUN_NORM));
      quietStep();
      checkOutput("back_in_run", 32'(obsOut), 32'(RUN_NORM));
      applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0);
      checkOutput("mem_wait_2", 32'(obsOut), 32'(WAITING));
      applyStimulus(0, 1, 5'd4, 5'd4, 5'd0, 0, 0, 0, 1, 1, 0);
      checkOutput("ready_with_loaduse", 32'(obsOut), 32'(STALL));
      quietStep();
      checkOutput("run_after_wait_stall", 32'(obsOut), 32'(RUN_NORM));

      // T5: memory timeout after wait count reaches 4
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0);
         checkOutput("timeout_wait", 32'(obsOut), 32'(WAITING));
      end
      applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0);
      checkOutput("timeout_halt", 32'(obsOut), 32'(HALT_ERR));
      applyStimulus(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 1, 0);
      checkOutput("halt_frozen", 32'(obsOut), 32'(HALT_ERR));
      pulseReset("reset_from_halt");

      // T6: halt from write-back, then reset mid-wait
      applyStimulus(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1);
      checkOutput("wb_halt_cycle", 32'(obsOut), 32'(RUN_NORM));
      quietStep();
      checkOutput("wb_halt_halted", 32'(obsOut), 32'(ALL_OFF));
      pulseReset("reset_after_wbhalt");
      applyStimulus(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0);
      checkOutput("pre_reset_wait", 32'(obsOut), 32'(WAITING));
      applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0);
      checkOutput("pre_reset_wait_2", 32'(obsOut), 32'(WAITING));
      pulseReset("reset_mid_wait");
`ifdef PIPE_STALL_CTRL_PERF_EN
      checkOutput("perf_stall_zero", perfStallCnt, 32'd0);
      checkOutput("perf_flush_zero", perfFlushCnt, 32'd0);
`endif
      quietStep();
      checkOutput("idle_after_reset", 32'(obsOut), 32'(ALL_OFF));

      // Wait counter must restart from scratch: full 5-cycle timeout again
      applyStimulus(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0);
         checkOutput("timeout_wait_2", 32'(obsOut), 32'(WAITING));
      end
      quietStep();
      checkOutput("timeout_halt_2", 32'(obsOut), 32'(HALT_ERR));

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
